// File: rtl/gtrg_rdout_seq_if.sv
// Bus between the GTRG readout sequencer and its surroundings: FIFO head, source
// readout handshake and the header/trailer word stream.
interface gtrg_rdout_seq_if;
  // GTRG FIFO side
  logic        EMPTY_B;
  logic [16:0] DAVSOUT;
  logic [11:0] BXCOUNTOUT;
  logic [3:0]  CFEBBX;
  logic        POP;

  // Source readout side
  logic [6:0]  SRCMASK;
  logic [6:0]  RDDONE;
  logic [6:0]  RDREQ;

  // Word stream towards the DMB data path
  logic [15:0] WORD;
  logic        WORD_VALID;
  logic        WORD_RDY;

  // Status
  logic        BUSY;
  logic [6:0]  TOERR;
  logic [15:0] EVTCNT;

  // Sequencer side
  modport master (
    input  EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, SRCMASK, RDDONE, WORD_RDY,
    output POP, RDREQ, WORD, WORD_VALID, BUSY, TOERR, EVTCNT
  );

  // FIFO / sources / downstream side
  modport slave (
    output EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, SRCMASK, RDDONE, WORD_RDY,
    input  POP, RDREQ, WORD, WORD_VALID, BUSY, TOERR, EVTCNT
  );
endinterface

// File: rtl/gtrg_rdout_seq.sv
// GTRG FIFO consumer: pops one L1A entry, emits a 3-word header, walks the flagged
// sources with a per-source readout timeout, then emits a trailer word.
module gtrg_rdout_seq #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input logic              CLK,
  input logic              RST,
  gtrg_rdout_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    CAPT,
    H1,
    H2,
    H3,
    SCAN,
    REQ,
    TRL
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;

  state_t           state;

  // Event registers, frozen from CAPT until the trailer is accepted
  logic [16:0]      dav;
  logic [11:0]      bx;
  logic [3:0]       cfebbx;
  logic [6:0]       toerr;

  logic [2:0]       idx;
  logic [TMO_W-1:0] tmo;

  logic [6:0]       flags;
  logic [6:0]       sel;
  logic [6:0]       toerr_upd;
  logic             need;
  logic             done_hit;
  logic             expire;
  logic             last;
  logic             xfer;
  logic [15:0]      h2_word;
  logic [15:0]      h3_word;
  logic [15:0]      trl_word;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    flags     = {dav[5:1], dav[0], dav[16]};
    sel       = 7'b000_0001 << idx;
    need      = |(flags & ~bus.SRCMASK & sel);
    done_hit  = |(bus.RDDONE & sel);
    expire    = (tmo == TMO_W'(TMO_MAX));
    last      = (idx == LAST_IDX);
    xfer      = bus.WORD_VALID & bus.WORD_RDY;

    // Done wins over expiry in the same cycle; only a bare expiry flags the source.
    toerr_upd = toerr;
    if ((state == REQ) && expire && !done_hit) begin
      toerr_upd = toerr | sel;
    end

    h2_word   = {4'hA, dav[16], dav[0], dav[5:1], dav[15:11]};
    h3_word   = {4'hB, cfebbx, 3'b000, dav[10:6]};
    trl_word  = {4'hE, 5'b0_0000, toerr_upd};
  end

  // NOTE: state and registered outputs use non-blocking assignments so every update lands on the clock edge together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      dav            <= '0;
      bx             <= '0;
      cfebbx         <= '0;
      toerr          <= '0;
      idx            <= '0;
      tmo            <= '0;
      bus.POP        <= 1'b0;
      bus.RDREQ      <= '0;
      bus.WORD       <= '0;
      bus.WORD_VALID <= 1'b0;
      bus.BUSY       <= 1'b0;
      bus.TOERR      <= '0;
      bus.EVTCNT     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.EMPTY_B) begin
            state    <= SETTLE;
            bus.BUSY <= 1'b1;
          end
        end

        // Head data needs two edges after EMPTY_B rises; the pop strobe is
        // only raised if the FIFO still reports data.
        SETTLE: begin
          if (bus.EMPTY_B) begin
            state   <= CAPT;
            bus.POP <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        CAPT: begin
          dav            <= bus.DAVSOUT;
          bx             <= bus.BXCOUNTOUT;
          cfebbx         <= bus.CFEBBX;
          toerr          <= '0;
          bus.POP        <= 1'b0;
          bus.WORD       <= {4'h9, bus.BXCOUNTOUT};
          bus.WORD_VALID <= 1'b1;
          state          <= H1;
        end

        H1: begin
          if (xfer) begin
            bus.WORD <= h2_word;
            state    <= H2;
          end
        end

        H2: begin
          if (xfer) begin
            bus.WORD <= h3_word;
            state    <= H3;
          end
        end

        H3: begin
          if (xfer) begin
            bus.WORD       <= '0;
            bus.WORD_VALID <= 1'b0;
            idx            <= '0;
            state          <= SCAN;
          end
        end

        SCAN: begin
          if (need) begin
            bus.RDREQ <= sel;
            tmo       <= '0;
            state     <= REQ;
          end else if (last) begin
            bus.WORD       <= trl_word;
            bus.WORD_VALID <= 1'b1;
            state          <= TRL;
          end else begin
            idx <= idx + 3'd1;
          end
        end

        REQ: begin
          if (done_hit || expire) begin
            bus.RDREQ <= '0;
            toerr     <= toerr_upd;
            if (last) begin
              bus.WORD       <= trl_word;
              bus.WORD_VALID <= 1'b1;
              state          <= TRL;
            end else begin
              idx   <= idx + 3'd1;
              state <= SCAN;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        TRL: begin
          if (xfer) begin
            bus.WORD       <= '0;
            bus.WORD_VALID <= 1'b0;
            bus.TOERR      <= toerr;
            bus.EVTCNT     <= bus.EVTCNT + 16'd1;
            bus.BUSY       <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
  end

  // Interface contract seen from the sequencer side
  a_pop_nonempty: assert property (@(posedge CLK) disable iff (RST)
    bus.POP |-> bus.EMPTY_B);

  a_rdreq_onehot: assert property (@(posedge CLK) disable iff (RST)
    $onehot0(bus.RDREQ));

  a_word_hold: assert property (@(posedge CLK) disable iff (RST)
    (bus.WORD_VALID && !bus.WORD_RDY) |=> (bus.WORD_VALID && $stable(bus.WORD)));

endmodule

// File: tb/tb_gtrg_rdout_seq.sv
// Self-checking bench for gtrg_rdout_seq: FIFO/source/downstream environment driven
// from random and directed events, checked against an event-level reference model.
module tb_gtrg_rdout_seq;

  localparam int TMO_MAX = 200;
  localparam int NEVER   = 1000;

  typedef struct {
    logic [16:0] dav;
    logic [11:0] bx;
    logic [3:0]  cfebbx;
    logic [6:0]  mask;
    int          dly[7];  // cycles after RDREQ rises before RDDONE; > TMO_MAX = never
  } evt_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  gtrg_rdout_seq_if bus ();

  gtrg_rdout_seq #(.TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment state
  evt_t        fifo_q[$];
  evt_t        batch_q[$];
  evt_t        cur;
  int          age = 0;
  bit          pend_pop = 1'b0;
  logic [6:0]  prev_rdreq = '0;
  int          req_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_word = '0;
  logic [15:0] prev_evtcnt = '0;
  int          pop_cnt = 0;
  int          cyc = 0;
  int          last_pop = -1000;
  int          rdy_mode = 0;  // 0 random, 1 always ready, 2 stall 5 cycles on the H2 word
  int          stall_n = 0;
  int          evt_total = 0;

  logic [15:0] obs_words[$];
  logic [6:0]  obs_req_bits[$];
  int          obs_req_len[$];
  logic [6:0]  obs_toerr[$];

  function automatic int onehot_idx(input logic [6:0] r);
    for (int i = 0; i < 7; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic evt_t mk(input logic [16:0] dav, input logic [11:0] bx,
                              input logic [3:0] cb, input logic [6:0] mask, input int d);
    evt_t e;
    e.dav = dav; e.bx = bx; e.cfebbx = cb; e.mask = mask;
    foreach (e.dly[i]) e.dly[i] = d;
    return e;
  endfunction

  task automatic tb_clear();
    fifo_q.delete();
    obs_words.delete(); obs_req_bits.delete(); obs_req_len.delete(); obs_toerr.delete();
    pend_pop = 1'b0; prev_rdreq = '0; req_cyc = 0; prev_stall = 1'b0;
    prev_evtcnt = '0; pop_cnt = 0; last_pop = -1000; age = 0;
    cur = mk(17'h0, 12'h0, 4'h0, 7'h00, 0);
  endtask

  // One environment step, run 1 ns after every rising edge.
  task automatic env_step();
    logic [6:0] r;
    logic [6:0] rdd;
    logic       rdy;
    bit         popped;
    popped = 1'b0;
    cyc++;
    if (pend_pop) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      pend_pop = 1'b0;
      popped   = 1'b1;
    end

    if (prev_stall) begin
      check("hold_valid", 32'(bus.WORD_VALID), 32'd1);
      check("hold_word", 32'(bus.WORD), 32'(prev_word));
    end

    r = bus.RDREQ;
    if (r != prev_rdreq) begin
      if (prev_rdreq != 0) begin
        obs_req_bits.push_back(prev_rdreq);
        obs_req_len.push_back(req_cyc + 1);
      end
      req_cyc = 0;
    end else if (r != 0) begin
      req_cyc++;
    end
    prev_rdreq = r;

    if (bus.POP) begin
      pop_cnt++;
      check("pop_nonempty", 32'(bus.EMPTY_B), 32'd1);
      check("pop_busy", 32'(bus.BUSY), 32'd1);
      check("pop_gap_ge6", 32'((cyc - last_pop) >= 6), 32'd1);
      last_pop = cyc;
      if (fifo_q.size() > 0) cur = fifo_q[0];
      pend_pop = 1'b1;
    end

    if (bus.EVTCNT != prev_evtcnt) begin
      obs_toerr.push_back(bus.TOERR);
      prev_evtcnt = bus.EVTCNT;
    end

    // FIFO head: valid two edges after EMPTY_B rises or after a pop, junk before.
    if (popped || (!bus.EMPTY_B && fifo_q.size() > 0)) age = 0;
    else if (age < 1000) age++;
    bus.EMPTY_B = (fifo_q.size() > 0);
    if (fifo_q.size() > 0 && age >= 2) begin
      bus.DAVSOUT    = fifo_q[0].dav;
      bus.BXCOUNTOUT = fifo_q[0].bx;
      bus.CFEBBX     = fifo_q[0].cfebbx;
    end else begin
      bus.DAVSOUT    = 17'($urandom);
      bus.BXCOUNTOUT = 12'($urandom);
      bus.CFEBBX     = 4'($urandom);
    end

    bus.SRCMASK = cur.mask;
    rdd = 7'($urandom) & ~r;
    if (r != 0 && req_cyc == cur.dly[onehot_idx(r)]) rdd = rdd | r;
    bus.RDDONE = rdd;

    case (rdy_mode)
      1: rdy = 1'b1;
      2: begin
        rdy = 1'b1;
        if (bus.WORD_VALID && bus.WORD[15:12] == 4'hA && stall_n < 5) begin
          rdy = 1'b0;
          stall_n++;
        end
      end
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    bus.WORD_RDY = rdy;

    if (bus.WORD_VALID && rdy) obs_words.push_back(bus.WORD);
    prev_stall = bus.WORD_VALID && !rdy;
    prev_word  = bus.WORD;
  endtask

  initial begin : env
    forever begin
      @(posedge CLK);
      #1;
      env_step();
    end
  end

  // Push batch_q into the FIFO, wait for all events, compare against the model.
  task automatic run_batch(input int gap_max);
    int          n;
    int          waited;
    logic [15:0] ew[$];
    logic [6:0]  eb[$];
    int          el[$];
    logic [6:0]  et[$];
    n = batch_q.size();
    obs_words.delete(); obs_req_bits.delete(); obs_req_len.delete(); obs_toerr.delete();
    pop_cnt = 0;

    foreach (batch_q[k]) begin
      int d, flag, te;
      d  = int'(batch_q[k].dav);
      te = 0;
      ew.push_back(16'(32'h9000 + int'(batch_q[k].bx)));
      ew.push_back(16'(32'hA000 + (((d >> 16) & 1) << 11) + ((d & 1) << 10)
                       + (((d >> 1) & 31) << 5) + ((d >> 11) & 31)));
      ew.push_back(16'(32'hB000 + (int'(batch_q[k].cfebbx) << 8) + ((d >> 6) & 31)));
      for (int i = 0; i < 7; i++) begin
        if (i == 0) flag = (d >> 16) & 1;
        else if (i == 1) flag = d & 1;
        else flag = (d >> (i - 1)) & 1;
        if (flag == 1 && batch_q[k].mask[i] == 1'b0) begin
          eb.push_back(7'(1 << i));
          if (batch_q[k].dly[i] > TMO_MAX) begin
            el.push_back(TMO_MAX + 1);
            te = te + (1 << i);
          end else begin
            el.push_back(batch_q[k].dly[i] + 1);
          end
        end
      end
      ew.push_back(16'(32'hE000 + te));
      et.push_back(7'(te));
    end

    foreach (batch_q[k]) begin
      @(negedge CLK);
      fifo_q.push_back(batch_q[k]);
      repeat ($urandom_range(0, gap_max)) @(negedge CLK);
    end

    waited = 0;
    while (obs_toerr.size() < n && waited < 4000 * n) begin
      @(negedge CLK);
      waited++;
    end
    repeat (2) @(negedge CLK);

    check("evt_done", 32'(obs_toerr.size()), 32'(n));
    check("pop_count", 32'(pop_cnt), 32'(n));
    check("n_words", 32'(obs_words.size()), 32'(ew.size()));
    for (int k = 0; k < ew.size() && k < obs_words.size(); k++)
      check($sformatf("word%0d", k), 32'(obs_words[k]), 32'(ew[k]));
    check("n_rdreq", 32'(obs_req_bits.size()), 32'(eb.size()));
    for (int k = 0; k < eb.size() && k < obs_req_bits.size(); k++) begin
      check($sformatf("rdreq%0d", k), 32'(obs_req_bits[k]), 32'(eb[k]));
      check($sformatf("rdreq_len%0d", k), 32'(obs_req_len[k]), 32'(el[k]));
    end
    for (int k = 0; k < et.size() && k < obs_toerr.size(); k++)
      check($sformatf("toerr%0d", k), 32'(obs_toerr[k]), 32'(et[k]));
    evt_total += n;
    check("evtcnt", 32'(bus.EVTCNT), 32'(evt_total));
    check("busy_idle", 32'(bus.BUSY), 32'd0);
    batch_q.delete();
  endtask

  initial begin : main
    evt_t e;
    int   waited;
    bus.EMPTY_B = 1'b0; bus.DAVSOUT = '0; bus.BXCOUNTOUT = '0; bus.CFEBBX = '0;
    bus.SRCMASK = '0; bus.RDDONE = '0; bus.WORD_RDY = 1'b0;
    tb_clear();
    repeat (3) @(negedge CLK);
    check("rst_pop", 32'(bus.POP), 32'd0);
    check("rst_word_valid", 32'(bus.WORD_VALID), 32'd0);
    check("rst_evtcnt", 32'(bus.EVTCNT), 32'd0);
    RST = 1'b0;
    tb_clear();
    repeat (2) @(negedge CLK);

    // Lone CFEB3 that never answers: full timeout
    rdy_mode = 1;
    batch_q.push_back(mk(17'h00008, 12'h3C4, 4'h2, 7'h00, NEVER));
    run_batch(0);
    check("t3_len", 32'(obs_req_len.size() > 0 ? obs_req_len[0] : 0), 32'(TMO_MAX + 1));
    check("t3_trailer", 32'(obs_words.size() > 3 ? obs_words[3] : 16'h0), 32'h0000_E010);
    check("t3_toerr", 32'(bus.TOERR), 32'h10);

    // Reset in the middle of a readout request
    fifo_q.push_back(mk(17'h10000, 12'h055, 4'h1, 7'h00, NEVER));
    waited = 0;
    while (bus.RDREQ == 0 && waited < 500) begin @(negedge CLK); waited++; end
    check("t1_rdreq", 32'(bus.RDREQ), 32'h01);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    tb_clear();
    #1;
    check("t1_pop", 32'(bus.POP), 32'd0);
    check("t1_rdreq_clr", 32'(bus.RDREQ), 32'd0);
    check("t1_word_valid", 32'(bus.WORD_VALID), 32'd0);
    check("t1_busy", 32'(bus.BUSY), 32'd0);
    check("t1_toerr", 32'(bus.TOERR), 32'd0);
    check("t1_evtcnt", 32'(bus.EVTCNT), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    tb_clear();
    evt_total = 0;
    repeat (5) @(negedge CLK);
    check("t1_idle_busy", 32'(bus.BUSY), 32'd0);
    check("t1_idle_pop", 32'(bus.POP), 32'd0);

    // ALCT, TMB, CFEB1 answering 3 cycles after each request
    batch_q.push_back(mk(17'h10003, 12'h123, 4'h5, 7'h00, 3));
    run_batch(0);
    if (obs_words.size() >= 4) begin
      check("t2_h1", 32'(obs_words[0]), 32'h9123);
      check("t2_h2", 32'(obs_words[1]), 32'hAC20);
      check("t2_h3", 32'(obs_words[2]), 32'hB500);
      check("t2_trl", 32'(obs_words[3]), 32'hE000);
    end else begin
      check("t2_words", 32'(obs_words.size()), 32'd4);
    end
    check("t2_evtcnt", 32'(bus.EVTCNT), 32'd1);

    // Everything flagged, everything masked
    batch_q.push_back(mk(17'h1FFFF, 12'hABC, 4'hF, 7'h7F, 0));
    run_batch(0);
    check("t4_no_rdreq", 32'(obs_req_bits.size()), 32'd0);

    // Downstream stalls the H2 word
    rdy_mode = 2;
    stall_n  = 0;
    batch_q.push_back(mk(17'h0A5A5, 12'h777, 4'h9, 7'h00, 1));
    run_batch(0);
    check("t5_stalls", 32'(stall_n), 32'd5);

    // Three entries back-to-back; the first answers exactly at expiry
    rdy_mode = 1;
    e = mk(17'h00004, 12'h001, 4'h1, 7'h00, TMO_MAX);
    batch_q.push_back(e);
    batch_q.push_back(mk(17'h00001, 12'h002, 4'h2, 7'h00, 0));
    batch_q.push_back(mk(17'h10020, 12'h003, 4'h3, 7'h00, 2));
    run_batch(0);
    check("t6_expiry_no_toerr", 32'(obs_toerr.size() > 0 ? obs_toerr[0] : 7'h7F), 32'd0);

    // Random events, random masks, random readiness and source latencies
    rdy_mode = 0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 6; k++) begin
        e = mk(17'($urandom), 12'($urandom), 4'($urandom), 7'($urandom & $urandom), 0);
        foreach (e.dly[i]) begin
          int sel;
          sel = $urandom_range(0, 19);
          if (sel < 14) e.dly[i] = $urandom_range(0, 6);
          else if (sel < 17) e.dly[i] = TMO_MAX;
          else e.dly[i] = NEVER;
        end
        batch_q.push_back(e);
      end
      run_batch(b * 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
